dual_port_bram_byte_en_pipe: RTL and testbench

- Next-generation true dual-port byte-enable BRAM for the cache and main-memory hierarchy.
- Adds a configurable read-latency pipeline with per-port read-valid strobes.
- Adds selectable read-during-write semantics and selectable write-collision resolution (port-1 priority or byte merge).
- Adds a hardware memory-clear state machine, triggered by reset or by request, plus a saturating collision counter for debug.

---
 rtl/dual_port_bram_byte_en_pipe.sv | 137 +++++++++++++
 tb/tb_dual_port_bram_byte_en_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_bram_byte_en_pipe.sv
// rtl/dual_port_bram_byte_en_pipe.sv - true dual-port byte-enable BRAM with read-latency pipeline,
// selectable read-during-write and write-collision handling, hardware memory clear and collision counter.
module dual_port_bram_byte_en_pipe #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int WRITE_FIRST    = 1,
   parameter int COLLISION_MODE = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    readEnable_1,
   input  logic                    writeEnable_1,
   input  logic [DATA_WIDTH/8-1:0] writeByteEnable_1,
   input  logic [ADDR_WIDTH-1:0]   address_1,
   input  logic [DATA_WIDTH-1:0]   writeData_1,
   output logic [DATA_WIDTH-1:0]   readData_1,
   output logic                    readValid_1,
   input  logic                    readEnable_2,
   input  logic                    writeEnable_2,
   input  logic [DATA_WIDTH/8-1:0] writeByteEnable_2,
   input  logic [ADDR_WIDTH-1:0]   address_2,
   input  logic [DATA_WIDTH-1:0]   writeData_2,
   output logic [DATA_WIDTH-1:0]   readData_2,
   output logic                    readValid_2,
   input  logic                    clear_start,
   output logic                    clear_busy,
   output logic [15:0]             collision_count
);
   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   typedef enum logic {IDLE, CLEAR} clearState_t;

   clearState_t           state, stateNext;
   logic [ADDR_WIDTH-1:0] clearAddr;
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  accept, collision, writeAccept1, writeAccept2;
   logic [1:0]            readAccept;
   logic [ADDR_WIDTH-1:0] portAddr [2];
   logic [DATA_WIDTH-1:0] readWord [2];
   logic [DATA_WIDTH-1:0] portReadData [2];
   logic [1:0]            portReadValid;

   assign clear_busy    = (state == CLEAR);
   assign accept        = !clear_busy;
   assign collision     = accept && writeEnable_1 && writeEnable_2 && (address_1 == address_2);
   assign writeAccept1  = accept && writeEnable_1;
   // In port-1-priority mode a colliding port-2 write is dropped whole, not just its overlapping bytes
   assign writeAccept2  = accept && writeEnable_2 && !(collision && (COLLISION_MODE == 0));
   assign readAccept    = {accept && readEnable_2, accept && readEnable_1};
   assign portAddr[0]   = address_1;
   assign portAddr[1]   = address_2;

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (clear_start) stateNext = CLEAR;
         CLEAR:   if (clearAddr == '1) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         clearAddr       <= '0;
         collision_count <= '0;
      end else begin
         state     <= stateNext;
         clearAddr <= clear_busy ? clearAddr + ADDR_ONE : '0;
         if (collision && (collision_count != 16'hFFFF))
            collision_count <= collision_count + 16'd1;
      end
   end

   // Post-write view of each read address; port 1 is applied last so it wins overlapping bytes
   always_comb begin
      logic [DATA_WIDTH-1:0] oldWord;
      logic [DATA_WIDTH-1:0] newWord;
      for (int p = 0; p < 2; p++) begin
         oldWord = mem[portAddr[p]];
         newWord = oldWord;
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (writeAccept2 && writeByteEnable_2[b] && (address_2 == portAddr[p]))
               newWord[b*8 +: 8] = writeData_2[b*8 +: 8];
            if (writeAccept1 && writeByteEnable_1[b] && (address_1 == portAddr[p]))
               newWord[b*8 +: 8] = writeData_1[b*8 +: 8];
         end
         readWord[p] = (WRITE_FIRST != 0) ? newWord : oldWord;
      end
   end

   always_ff @(posedge clock) begin
      if (clear_busy) begin
         mem[clearAddr] <= '0;
      end else begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (writeAccept2 && writeByteEnable_2[b])
               mem[address_2][b*8 +: 8] <= writeData_2[b*8 +: 8];
            if (writeAccept1 && writeByteEnable_1[b])
               mem[address_1][b*8 +: 8] <= writeData_1[b*8 +: 8];
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : gPort
      logic [DATA_WIDTH-1:0]   stageData [READ_LATENCY];
      logic [READ_LATENCY-1:0] stageValid;

      // Each stage only loads when the stage before it carries a valid read, so the last stage holds
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            stageValid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) stageData[k] <= '0;
         end else begin
            stageValid[0] <= readAccept[p];
            if (readAccept[p]) stageData[0] <= readWord[p];
            for (int k = 1; k < READ_LATENCY; k++) begin
               stageValid[k] <= stageValid[k-1];
               if (stageValid[k-1]) stageData[k] <= stageData[k-1];
            end
         end
      end

      assign portReadData[p]  = stageData[READ_LATENCY-1];
      assign portReadValid[p] = stageValid[READ_LATENCY-1];
   end

   assign readData_1  = portReadData[0];
   assign readData_2  = portReadData[1];
   assign readValid_1 = portReadValid[0];
   assign readValid_2 = portReadValid[1];
endmodule

// File: tb/tb_dual_port_bram_byte_en_pipe.sv
// tb/tb_dual_port_bram_byte_en_pipe.sv - bench for two configurations of dual_port_bram_byte_en_pipe
// (A: latency 3, write-first, byte merge; B: latency 1, read-first, port-1 priority) driven in lockstep.
module tb_dual_port_bram_byte_en_pipe;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        re1, we1, re2, we2, clearStart;
   logic [3:0]  be1, be2, a1, a2;
   logic [31:0] wd1, wd2;
   logic [31:0] rdA1, rdA2, rdB1, rdB2;
   logic        rvA1, rvA2, rvB1, rvB2, busyA, busyB;
   logic [15:0] cntA, cntB;

   always #5 clock = ~clock;

   dual_port_bram_byte_en_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(3), .WRITE_FIRST(1),
      .COLLISION_MODE(1), .CLEAR_ON_RESET(1)) dutA (
      .clock(clock), .reset(reset),
      .readEnable_1(re1), .writeEnable_1(we1), .writeByteEnable_1(be1), .address_1(a1),
      .writeData_1(wd1), .readData_1(rdA1), .readValid_1(rvA1),
      .readEnable_2(re2), .writeEnable_2(we2), .writeByteEnable_2(be2), .address_2(a2),
      .writeData_2(wd2), .readData_2(rdA2), .readValid_2(rvA2),
      .clear_start(clearStart), .clear_busy(busyA), .collision_count(cntA));

   dual_port_bram_byte_en_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_FIRST(0),
      .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) dutB (
      .clock(clock), .reset(reset),
      .readEnable_1(re1), .writeEnable_1(we1), .writeByteEnable_1(be1), .address_1(a1),
      .writeData_1(wd1), .readData_1(rdB1), .readValid_1(rvB1),
      .readEnable_2(re2), .writeEnable_2(we2), .writeByteEnable_2(be2), .address_2(a2),
      .writeData_2(wd2), .readData_2(rdB2), .readValid_2(rvB2),
      .clear_start(clearStart), .clear_busy(busyB), .collision_count(cntB));

   int errs = 0;
   int checks = 0;
   int cyc = 0;

   // Reference model: per-instance memory image, clear progress, and a per-cycle schedule of read returns
   int          LAT [2] = '{3, 1};
   int          WF  [2] = '{1, 0};
   int          CM  [2] = '{1, 0};
   logic [31:0] memM [2][16];
   int          clearLeft = 0;
   int          clearPtr = 0;
   int          cnt = 0;
   bit          expV [4][4096];
   logic [31:0] expD [4][4096];
   logic [31:0] lastD [4];

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] pre;
      logic        we1;
      logic [3:0]  be1;
      logic [31:0] wd1;
      logic        re1;
      logic        we2;
      logic [3:0]  be2;
      logic [31:0] wd2;
      logic        re2;
      logic [31:0] rdA, rdB, finA, finB;
      int          collInc;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] applyBytes(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = nw[8*i +: 8];
      return old;
   endfunction

   function automatic logic [31:0] newAt(int inst, logic [3:0] a, bit coll);
      logic [31:0] w;
      w = memM[inst][a];
      if (we2 && !(coll && CM[inst] == 0) && a2 == a) w = applyBytes(w, wd2, be2);
      if (we1 && a1 == a) w = applyBytes(w, wd1, be1);
      return w;
   endfunction

   task automatic sched(input int s, input int due, input logic [31:0] d);
      if (due < 4096) begin
         expV[s][due] = 1'b1;
         expD[s][due] = d;
      end
   endtask

   task automatic modelEdge();
      int          t;
      bit          coll;
      logic [31:0] n1, n2;
      t = cyc + 1;
      if (clearLeft > 0) begin
         for (int inst = 0; inst < 2; inst++) memM[inst][clearPtr] = 32'h0;
         clearPtr++;
         clearLeft--;
      end else begin
         coll = we1 && we2 && (a1 == a2);
         if (coll && cnt != 65535) cnt++;
         for (int inst = 0; inst < 2; inst++) begin
            n1 = newAt(inst, a1, coll);
            n2 = newAt(inst, a2, coll);
            if (re1) sched(inst*2,     t + LAT[inst] - 1, WF[inst] != 0 ? n1 : memM[inst][a1]);
            if (re2) sched(inst*2 + 1, t + LAT[inst] - 1, WF[inst] != 0 ? n2 : memM[inst][a2]);
            memM[inst][a1] = n1;
            memM[inst][a2] = n2;
         end
         if (clearStart) begin
            clearLeft = 16;
            clearPtr  = 0;
         end
      end
   endtask

   task automatic checkCycle();
      logic [31:0] ad [4];
      logic        av [4];
      string       nm [4];
      nm = '{"A1", "A2", "B1", "B2"};
      ad = '{rdA1, rdA2, rdB1, rdB2};
      av = '{rvA1, rvA2, rvB1, rvB2};
      for (int s = 0; s < 4; s++) begin
         chk({nm[s], " readValid"}, 32'(av[s]), 32'(expV[s][cyc]));
         if (expV[s][cyc]) lastD[s] = expD[s][cyc];
         chk({nm[s], " readData"}, ad[s], lastD[s]);
      end
      chk("A clear_busy", 32'(busyA), 32'(clearLeft > 0));
      chk("B clear_busy", 32'(busyB), 32'(clearLeft > 0));
      chk("A collision_count", 32'(cntA), 32'(cnt));
      chk("B collision_count", 32'(cntB), 32'(cnt));
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clock);
      cyc++;
      @(negedge clock);
      checkCycle();
   endtask

   task automatic idle();
      re1 = 0; we1 = 0; re2 = 0; we2 = 0; clearStart = 0;
   endtask

   task automatic doReset();
      idle();
      #2 reset = 1'b0;
      #1;
      chk("reset readData A1", rdA1, 32'h0);
      chk("reset readData A2", rdA2, 32'h0);
      chk("reset readData B1", rdB1, 32'h0);
      chk("reset readData B2", rdB2, 32'h0);
      chk("reset readValid", 32'({rvA1, rvA2, rvB1, rvB2}), 32'h0);
      chk("reset clear_busy", 32'({busyA, busyB}), 32'h3);
      chk("reset collision_count", 32'({cntA, cntB}), 32'h0);
      for (int s = 0; s < 4; s++) begin
         lastD[s] = 32'h0;
         for (int k = cyc + 1; k < cyc + 9 && k < 4096; k++) expV[s][k] = 1'b0;
      end
      cnt = 0;
      clearLeft = 16;
      clearPtr = 0;
      @(posedge clock); cyc++;
      @(posedge clock); cyc++;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic capture(input int port, output logic [31:0] cA, output logic [31:0] cB,
                          output int tA, output int tB);
      cA = 32'hBAD0BAD0; cB = 32'hBAD0BAD0; tA = 0; tB = 0;
      for (int t = 1; t <= 4; t++) begin
         tick();
         if (t == 1) idle();
         if ((port == 1) ? rvA1 : rvA2) begin cA = (port == 1) ? rdA1 : rdA2; tA = t; end
         if ((port == 1) ? rvB1 : rvB2) begin cB = (port == 1) ? rdB1 : rdB2; tB = t; end
      end
   endtask

   task automatic countClear(input string nm);
      int n;
      n = 0;
      while (busyA && n < 40) begin
         tick();
         idle();
         n++;
      end
      chk(nm, 32'(n), 32'd16);
   endtask

   task automatic writeWord(input logic [3:0] a, input logic [31:0] d);
      we1 = 1; be1 = 4'hF; a1 = a; wd1 = d;
      tick();
      idle();
   endtask

   initial begin
      logic [31:0] cA, cB;
      int          tA, tB, port, cb, nV;
      logic [31:0] seqExp [4];
      logic [31:0] qData [$];
      int          qCyc [$];

      idle();
      be1 = 0; be2 = 0; a1 = 0; a2 = 0; wd1 = 0; wd2 = 0;
      for (int i = 0; i < 2; i++) for (int j = 0; j < 16; j++) memM[i][j] = 32'h0;
      for (int s = 0; s < 4; s++) lastD[s] = 32'h0;

      vecs[0] = '{4'd5,  32'h11223344, 1, 4'b0101, 32'hAABBCCDD, 0, 0, 4'b0000, 32'h0, 0,
                  32'h0, 32'h0, 32'h11BB33DD, 32'h11BB33DD, 0};
      vecs[1] = '{4'd7,  32'h00000000, 1, 4'b0011, 32'h11111111, 0, 1, 4'b1110, 32'h22222222, 0,
                  32'h0, 32'h0, 32'h22221111, 32'h00001111, 1};
      vecs[2] = '{4'd9,  32'h00000000, 1, 4'b1111, 32'h5A5A5A5A, 0, 0, 4'b0000, 32'h0, 1,
                  32'h5A5A5A5A, 32'h00000000, 32'h5A5A5A5A, 32'h5A5A5A5A, 0};
      vecs[3] = '{4'd2,  32'h12345678, 1, 4'b0000, 32'hFFFFFFFF, 1, 0, 4'b0000, 32'h0, 0,
                  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 0};
      vecs[4] = '{4'd4,  32'hCAFEF00D, 1, 4'b1100, 32'h01020304, 1, 0, 4'b0000, 32'h0, 0,
                  32'h0102F00D, 32'hCAFEF00D, 32'h0102F00D, 32'h0102F00D, 0};
      vecs[5] = '{4'd11, 32'hFFFFFFFF, 1, 4'b1000, 32'h00000000, 0, 1, 4'b1001, 32'h12345678, 1,
                  32'h00FFFF78, 32'hFFFFFFFF, 32'h00FFFF78, 32'h00FFFFFF, 1};

      @(negedge clock);
      doReset();
      re1 = 1; a1 = 4'd0;
      countClear("clear cycles after reset");
      re1 = 1; a1 = 4'd6;
      capture(1, cA, cB, tA, tB);
      chk("cleared word A", cA, 32'h0);
      chk("cleared word B", cB, 32'h0);

      foreach (vecs[i]) begin
         writeWord(vecs[i].addr, vecs[i].pre);
         cb = int'(cntA);
         we1 = vecs[i].we1; be1 = vecs[i].be1; a1 = vecs[i].addr; wd1 = vecs[i].wd1; re1 = vecs[i].re1;
         we2 = vecs[i].we2; be2 = vecs[i].be2; a2 = vecs[i].addr; wd2 = vecs[i].wd2; re2 = vecs[i].re2;
         port = vecs[i].re1 ? 1 : (vecs[i].re2 ? 2 : 0);
         capture((port == 0) ? 1 : port, cA, cB, tA, tB);
         if (port != 0) begin
            chk($sformatf("vec%0d rdw A", i), cA, vecs[i].rdA);
            chk($sformatf("vec%0d rdw B", i), cB, vecs[i].rdB);
         end
         chk($sformatf("vec%0d collision delta", i), 32'(int'(cntA) - cb), 32'(vecs[i].collInc));
         re1 = 1; a1 = vecs[i].addr;
         capture(1, cA, cB, tA, tB);
         chk($sformatf("vec%0d final A", i), cA, vecs[i].finA);
         chk($sformatf("vec%0d final B", i), cB, vecs[i].finB);
      end

      writeWord(4'd0, 32'hA0A0A0A0);
      writeWord(4'd1, 32'hA1A1A1A1);
      writeWord(4'd2, 32'hA2A2A2A2);
      writeWord(4'd3, 32'hDEADBEEF);
      re1 = 1; a1 = 4'd3;
      capture(1, cA, cB, tA, tB);
      chk("latency A edges", 32'(tA), 32'd3);
      chk("latency B edges", 32'(tB), 32'd1);
      chk("latency A data", cA, 32'hDEADBEEF);
      seqExp = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hDEADBEEF};
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin re1 = 1; a1 = 4'(k); end else idle();
         tick();
         if (rvA1) begin qData.push_back(rdA1); qCyc.push_back(cyc); end
      end
      idle();
      chk("pipelined read count", 32'(qData.size()), 32'd4);
      for (int k = 0; k < qData.size() && k < 4; k++) chk($sformatf("pipelined read %0d", k), qData[k], seqExp[k]);
      if (qCyc.size() == 4) chk("pipelined read spacing", 32'(qCyc[3] - qCyc[0]), 32'd3);

      re1 = 1; a1 = 4'd3;
      tick();
      idle();
      clearStart = 1;
      tick();
      clearStart = 0;
      nV = 0;
      for (int k = 0; k < 6; k++) begin
         we1 = 1; be1 = 4'hF; a1 = 4'd3; wd1 = 32'hFFFFFFFF; re2 = 1; a2 = 4'd5; clearStart = 1;
         tick();
         nV += int'(rvA1) + int'(rvA2) + int'(rvB1) + int'(rvB2);
      end
      chk("valids during clear", 32'(nV), 32'd1);
      chk("busy mid clear", 32'(busyA), 32'd1);
      doReset();
      countClear("clear cycles after mid-clear reset");
      re1 = 1; a1 = 4'd3;
      capture(1, cA, cB, tA, tB);
      chk("write during clear dropped A", cA, 32'h0);
      chk("write during clear dropped B", cB, 32'h0);

      for (int k = 0; k < 400; k++) begin
         re1 = 1'($urandom); we1 = ($urandom_range(2) == 0); be1 = 4'($urandom); a1 = 4'($urandom); wd1 = $urandom;
         re2 = 1'($urandom); we2 = ($urandom_range(2) == 0); be2 = 4'($urandom); wd2 = $urandom;
         a2 = ($urandom_range(2) == 0) ? a1 : 4'($urandom);
         clearStart = ($urandom_range(149) == 0);
         tick();
      end
      idle();
      for (int k = 0; k < 40 && busyA; k++) tick();
      for (int k = 0; k < 5; k++) tick();
      chk("final clear_busy", 32'(busyA), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
